// File: rtl/fir_symbol_source.sv
// rtl/fir_symbol_source.sv - 2B1Q symbol source feeding the FIR pulse shaper
// Buffers 2-bit words, maps them to 2B1Q levels and zero-stuffs by OSR on a divided sample strobe.
module fir_symbol_source #(
  parameter int CLK_DIV    = 20,
  parameter int OSR        = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        iClk_12MHz,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic        iBitValid,
  input  logic [1:0]  iBitData,
  output logic        oBitReady,
  output logic        oEnSample_600kHz,
  output logic [2:0]  oFirIn,
  output logic        oUnderflow,
  output logic [15:0] oSymCnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OSR - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DIV_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             strobe_q, strobe_d;
  logic [2:0]       fir_q, fir_d;
  logic             uf_q, uf_d;
  logic [15:0]      sym_cnt_q, sym_cnt_d;
  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic tick;
  logic slot;
  logic push;
  logic pop;

  // Sign bit selects polarity, magnitude bit clear selects the outer level.
  function automatic logic [2:0] map_2b1q(input logic [1:0] w);
    logic [2:0] s;
    case (w)
      2'b10:   s = 3'b011;
      2'b11:   s = 3'b001;
      2'b01:   s = 3'b111;
      default: s = 3'b101;
    endcase
    return s;
  endfunction

  assign tick      = iEnable && (div_q == DIV_LAST);
  assign slot      = tick && (phase_q == '0);
  assign oBitReady = (count_q < CNT_FULL);
  assign push      = iBitValid && oBitReady;
  // Uses the registered count, so a word arriving on the slot edge waits for the next slot.
  assign pop       = slot && (count_q != '0);

  always_comb begin
    div_d     = div_q;
    phase_d   = phase_q;
    strobe_d  = tick;
    fir_d     = fir_q;
    uf_d      = slot && (count_q == '0);
    sym_cnt_d = sym_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (!iEnable) begin
      div_d   = '0;
      phase_d = '0;
      fir_d   = '0;
    end else begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      if (tick) begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        fir_d   = pop ? map_2b1q(mem_q[rd_ptr_q]) : 3'b000;
      end
    end

    if (pop) begin
      sym_cnt_d = sym_cnt_q + 16'd1;
      rd_ptr_d  = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iClk_12MHz or posedge iRst) begin
    if (iRst) begin
      div_q     <= '0;
      phase_q   <= '0;
      strobe_q  <= 1'b0;
      fir_q     <= '0;
      uf_q      <= 1'b0;
      sym_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      div_q     <= div_d;
      phase_q   <= phase_d;
      strobe_q  <= strobe_d;
      fir_q     <= fir_d;
      uf_q      <= uf_d;
      sym_cnt_q <= sym_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= iBitData;
      end
    end
  end

  assign oEnSample_600kHz = strobe_q;
  assign oFirIn           = fir_q;
  assign oUnderflow       = uf_q;
  assign oSymCnt          = sym_cnt_q;

endmodule

// File: tb/tb_fir_symbol_source.sv
// tb/tb_fir_symbol_source.sv - scoreboard bench for fir_symbol_source
// Stimulus queues the expected sample per strobe; a negedge monitor pops and compares.
module tb_fir_symbol_source;

  logic        clk = 1'b0;
  logic        rst, en, bit_valid;
  logic [1:0]  bit_data;
  logic        rdy, strobe, uf;
  logic [2:0]  fir;
  logic [15:0] symcnt;

  logic        f_rst, f_en, f_valid;
  logic [1:0]  f_data;
  logic        f_rdy, f_strobe, f_uf;
  logic [2:0]  f_fir;
  logic [15:0] f_symcnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_strobe = 0;
  bit have_last = 1'b0;
  bit fast_done = 1'b0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  fir_symbol_source #(.CLK_DIV(20), .OSR(3), .FIFO_DEPTH(2)) dut (
    .iClk_12MHz(clk), .iRst(rst), .iEnable(en), .iBitValid(bit_valid),
    .iBitData(bit_data), .oBitReady(rdy), .oEnSample_600kHz(strobe),
    .oFirIn(fir), .oUnderflow(uf), .oSymCnt(symcnt)
  );

  // Strobe every cycle, one sample per symbol: lets the 16-bit counter wrap quickly.
  fir_symbol_source #(.CLK_DIV(1), .OSR(1), .FIFO_DEPTH(2)) dut_fast (
    .iClk_12MHz(clk), .iRst(f_rst), .iEnable(f_en), .iBitValid(f_valid),
    .iBitData(f_data), .oBitReady(f_rdy), .oEnSample_600kHz(f_strobe),
    .oFirIn(f_fir), .oUnderflow(f_uf), .oSymCnt(f_symcnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_sample(input logic [2:0] f, input logic u);
    exp_q.push_back({f, u});
  endtask

  task automatic expect_seq(input logic [2:0] s0, input logic [2:0] s3, input logic [2:0] s6,
                            input logic u0, input logic u3, input logic u6);
    expect_sample(s0, u0); expect_sample(3'd0, 1'b0); expect_sample(3'd0, 1'b0);
    expect_sample(s3, u3); expect_sample(3'd0, 1'b0); expect_sample(3'd0, 1'b0);
    expect_sample(s6, u6);
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d samples still expected after %0d cycles", exp_q.size(), bound);
      exp_q.delete();
    end
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle_strobe", {31'd0, strobe}, 32'd0);
    chk("idle_fir", {29'd0, fir}, 32'd0);
    chk("idle_underflow", {31'd0, uf}, 32'd0);
  endtask

  // Call at a negedge; returns at the negedge after acceptance with valid still high.
  task automatic push_word(input logic [1:0] w, output int k);
    bit_valid = 1'b1;
    bit_data  = w;
    k = 0;
    while (!rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: ready stayed 0 for %0d cycles", k);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [3:0] e;
    if (rst || !en) have_last = 1'b0;
    if (!rst && strobe) begin
      if (have_last) chk("strobe_period", cyc - last_strobe, 32'd20);
      have_last   = 1'b1;
      last_strobe = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: fir=%0h underflow=%0b with nothing expected", fir, uf);
      end else begin
        e = exp_q.pop_front();
        chk("fir_in", {29'd0, fir}, {29'd0, e[3:1]});
        chk("underflow", {31'd0, uf}, {31'd0, e[0]});
      end
    end else if (!rst && uf) begin
      n_cmp++;
      n_err++;
      $display("FAIL underflow_without_strobe: got 1 expected 0");
    end
  end

  initial begin
    int k;
    f_rst = 1'b1; f_en = 1'b0; f_valid = 1'b0; f_data = 2'b10;
    repeat (3) @(negedge clk);
    f_rst = 1'b0;
    f_en = 1'b1;
    f_valid = 1'b1;
    k = 0;
    while (f_symcnt != 16'hFFFF && k < 70000) begin
      @(negedge clk);
      k++;
    end
    chk("fast_reach_ffff", {16'd0, f_symcnt}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    chk("symcnt_wrap", {16'd0, f_symcnt}, 32'd0);
    chk("fast_fir", {29'd0, f_fir}, 32'd3);
    f_en = 1'b0;
    f_valid = 1'b0;
    fast_done = 1'b1;
  end

  initial begin
    int k;
    rst = 1'b1; en = 1'b0; bit_valid = 1'b0; bit_data = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_strobe", {31'd0, strobe}, 32'd0);
    chk("rst_fir", {29'd0, fir}, 32'd0);
    chk("rst_underflow", {31'd0, uf}, 32'd0);
    chk("rst_symcnt", {16'd0, symcnt}, 32'd0);
    chk("rst_ready", {31'd0, rdy}, 32'd1);
    rst = 1'b0;

    // No data: underflow on every phase-0 slot, first strobe after 20 enabled edges.
    @(negedge clk);
    expect_seq(3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1);
    en = 1'b1;
    repeat (19) @(posedge clk);
    #1 chk("first_strobe_early", {31'd0, strobe}, 32'd0);
    @(posedge clk);
    #1 chk("first_strobe", {31'd0, strobe}, 32'd1);
    drain(200);
    chk("empty_symcnt", {16'd0, symcnt}, 32'd0);
    idle();

    // Preload while disabled, then run.
    push_word(2'b10, k);
    push_word(2'b01, k);
    bit_valid = 1'b0;
    chk("preload_full_ready", {31'd0, rdy}, 32'd0);
    expect_seq(3'b011, 3'b111, 3'd0, 1'b0, 1'b0, 1'b1);
    en = 1'b1;
    drain(200);
    chk("preload_symcnt", {16'd0, symcnt}, 32'd2);
    chk("preload_ready", {31'd0, rdy}, 32'd1);
    idle();

    // Continuous valid: third word waits until the first slot pops.
    expect_seq(3'b101, 3'b001, 3'b011, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    push_word(2'b00, k);
    push_word(2'b11, k);
    chk("stream_full_ready", {31'd0, rdy}, 32'd0);
    push_word(2'b10, k);
    chk("stream_ready_wait", k, 32'd18);
    bit_valid = 1'b0;
    drain(200);
    chk("stream_symcnt", {16'd0, symcnt}, 32'd5);
    idle();

    // Word arriving on the slot edge of an empty FIFO misses that slot.
    expect_seq(3'd0, 3'b001, 3'd0, 1'b1, 1'b0, 1'b1);
    en = 1'b1;
    repeat (19) @(posedge clk);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_data  = 2'b11;
    @(posedge clk);
    @(negedge clk);
    bit_valid = 1'b0;
    drain(200);
    chk("late_push_symcnt", {16'd0, symcnt}, 32'd6);
    idle();

    // Asynchronous reset mid-symbol with the FIFO full.
    push_word(2'b10, k);
    push_word(2'b01, k);
    bit_valid = 1'b0;
    expect_sample(3'b011, 1'b0);
    en = 1'b1;
    drain(100);
    @(negedge clk);
    push_word(2'b00, k);
    bit_valid = 1'b0;
    chk("pre_reset_ready", {31'd0, rdy}, 32'd0);
    chk("pre_reset_fir", {29'd0, fir}, 32'd3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_fir", {29'd0, fir}, 32'd0);
    chk("async_rst_symcnt", {16'd0, symcnt}, 32'd0);
    chk("async_rst_ready", {31'd0, rdy}, 32'd1);
    chk("async_rst_strobe", {31'd0, strobe}, 32'd0);
    expect_sample(3'd0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drain(100);
    chk("post_reset_symcnt", {16'd0, symcnt}, 32'd0);
    idle();

    k = 0;
    while (!fast_done && k < 80000) begin
      @(posedge clk);
      k++;
    end
    if (!fast_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wrap_timeout: fast instance did not finish in %0d cycles", k);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_symbol_source.md
Name: fir_symbol_source

Overview:
- Transmit-side sample source that drives the FIR pulse-shaping filter input.
- Accepts 2-bit data words over a valid/ready handshake and maps each word to a 2B1Q symbol in {-3,-1,+1,+3}.
- Zero-stuffs each symbol by the oversampling ratio and emits one 3-bit signed sample per sample strobe.
- Generates the 600 kHz sample-enable strobe from the 12 MHz clock; downstream logic consumes oFirIn on cycles where oEnSample_600kHz is high.

Parameters:
- CLK_DIV, 20, clock cycles per sample strobe (12 MHz / 600 kHz).
- OSR, 3, samples per symbol: one symbol sample followed by OSR-1 zero samples.
- FIFO_DEPTH, 2, input word buffer depth in entries.

Ports:
- iClk_12MHz  input  1  system clock, 12 MHz.
- iRst  input  1  reset, asynchronous, active-high.
- iEnable  input  1  run control; low holds the strobe generator and phase counter idle.
- iBitValid  input  1  input word valid.
- iBitData  input  2  input word; bit 1 is sign, bit 0 is magnitude.
- oBitReady  output  1  buffer can accept a word this cycle.
- oEnSample_600kHz  output  1  one-cycle sample strobe.
- oFirIn  output  3  signed sample to the FIR filter.
- oUnderflow  output  1  one-cycle pulse: a symbol slot was due but the buffer was empty.
- oSymCnt  output  16  count of symbols emitted, wraps modulo 2^16.

Behaviour:
- One clock domain. iRst is asynchronous and active-high.
- Reset values: oEnSample_600kHz=0, oFirIn=0, oUnderflow=0, oSymCnt=0, divider=0, phase=0, FIFO empty. oBitReady=1 after reset. Reset mid-operation discards buffered words.
- Divider counter:
  - Counts 0..CLK_DIV-1 while iEnable=1 and wraps.
  - oEnSample_600kHz is registered and is high for exactly the one cycle after the divider reaches CLK_DIV-1.
  - First strobe occurs CLK_DIV cycles after the first clock edge with iEnable=1; strobes then repeat every CLK_DIV cycles.
- iEnable=0: divider and phase clear to 0, oEnSample_600kHz=0, oFirIn=0, oUnderflow=0. FIFO contents and oSymCnt are retained, and the handshake stays active.
- Handshake and FIFO:
  - oBitReady = (count < FIFO_DEPTH), combinational from the registered count.
  - A word is accepted on a clock edge where iBitValid=1 and oBitReady=1.
  - iBitData must be held while iBitValid=1 and oBitReady=0.
  - Push and pop in the same cycle leave count unchanged. Pushes while full are not possible because ready is 0.
- Sample generation: oFirIn updates on the same edge that raises oEnSample_600kHz, so the value is stable during the strobe cycle and holds until the next strobe.
  - Phase 0 strobe, FIFO non-empty: pop the head, map it, oSymCnt += 1.
  - Phase 0 strobe, FIFO empty: oFirIn=0, oUnderflow pulses together with the strobe, oSymCnt unchanged.
  - Phase 1..OSR-1 strobe: oFirIn=0.
  - Phase advances 0..OSR-1 on every strobe and wraps, regardless of underflow.
- 2B1Q mapping (two's complement, 3 bits): 10 -> +3 (011), 11 -> +1 (001), 01 -> -1 (111), 00 -> -3 (101). The output never takes values -4, +2 or -2.
- A word pushed in the same cycle as a phase-0 strobe with an empty FIFO is not used for that slot; it is emitted at the next phase-0 strobe.

Test Plan:
- Reset then iEnable=1, no data -> oEnSample_600kHz pulses at cycles 20, 40, 60, ...; oUnderflow pulses at the 1st, 4th and 7th strobes; oFirIn stays 0.
- Preload words 10, 01 with iEnable=0, then enable -> strobe 1 gives oFirIn=+3, strobes 2-3 give 0, strobe 4 gives -1, strobes 5-6 give 0, strobe 7 gives oUnderflow=1; oSymCnt=2.
- Hold iBitValid=1 continuously with words 00, 11, 10, ... -> oBitReady drops after two accepts and reasserts the cycle after each phase-0 pop; sample sequence is -3,0,0,+1,0,0,+3; no underflow.
- Push a word exactly on a phase-0 strobe cycle with the FIFO empty -> that slot gives oFirIn=0 with oUnderflow=1; the word appears three strobes later.
- Assert iRst asynchronously mid-symbol with the FIFO full -> all outputs go to 0 immediately without a clock edge; oBitReady=1; after release and enable, the first strobe underflows.
- Force oSymCnt to 16'hFFFF (or run 65536 symbols) -> the next emitted symbol wraps it to 0.
